// File: rtl/cmm_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the complex matrix-multiply sequencer.
package cmm_sequencer_pkg;

  localparam int MATRIX_DIM = 4;
  localparam int WORD_LEN   = 16;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_DP_LAT = 2;

  // Selector "state" line values for the two passes of a complex product.
  localparam logic REAL_SET = 1'b0;
  localparam logic IMAG_SET = 1'b1;

  localparam logic PART_REAL = 1'b0;
  localparam logic PART_IMAG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int addrWidth(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/cmm_tag_pipe.sv
// Stallable delay line of issue tags {valid,row,col,part}, tapped where operands
// reach the selector (RD_LAT) and where results leave the dot-product unit (LAT).
module cmm_tag_pipe #(
  parameter int LAT    = 3,
  parameter int RD_LAT = 1,
  parameter int AW     = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          stall_i,
  input  logic          in_valid_i,
  input  logic [AW-1:0] in_row_i,
  input  logic [AW-1:0] in_col_i,
  input  logic          in_part_i,
  output logic          rd_valid_o,
  output logic          rd_part_o,
  output logic          out_valid_o,
  output logic [AW-1:0] out_row_o,
  output logic [AW-1:0] out_col_o,
  output logic          out_part_o,
  output logic          upstream_busy_o
);

  logic [LAT:1]  valid_q, valid_d;
  logic [LAT:1]  part_q, part_d;
  logic [AW-1:0] row_q [1:LAT];
  logic [AW-1:0] row_d [1:LAT];
  logic [AW-1:0] col_q [1:LAT];
  logic [AW-1:0] col_d [1:LAT];

  always_comb begin
    valid_d = valid_q;
    part_d  = part_q;
    row_d   = row_q;
    col_d   = col_q;
    if (!stall_i) begin
      valid_d[1] = in_valid_i;
      part_d[1]  = in_part_i;
      row_d[1]   = in_row_i;
      col_d[1]   = in_col_i;
      for (int k = 2; k <= LAT; k++) begin
        valid_d[k] = valid_q[k-1];
        part_d[k]  = part_q[k-1];
        row_d[k]   = row_q[k-1];
        col_d[k]   = col_q[k-1];
      end
    end
  end

  // Payload is cleared too so every write tag reads zero straight out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      part_q  <= '0;
      for (int k = 1; k <= LAT; k++) begin
        row_q[k] <= '0;
        col_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      part_q  <= part_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    upstream_busy_o = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      upstream_busy_o = upstream_busy_o | valid_q[k];
    end
  end

  assign rd_valid_o  = valid_q[RD_LAT];
  assign rd_part_o   = part_q[RD_LAT];
  assign out_valid_o = valid_q[LAT];
  assign out_row_o   = row_q[LAT];
  assign out_col_o   = col_q[LAT];
  assign out_part_o  = part_q[LAT];

endmodule

// File: rtl/cmm_sequencer.sv
// Sequences real and imaginary passes for every C[i][j] of a complex matrix multiply,
// issuing operand reads and tagging results, with result-sink backpressure.
module cmm_sequencer
  import cmm_sequencer_pkg::*;
#(
  parameter int DIM    = MATRIX_DIM,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int DP_LAT = DEF_DP_LAT,
  parameter int AW     = addrWidth(DIM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] a_row,
  output logic [AW-1:0] b_col,
  output logic          sel_state,
  output logic          dp_sub,
  output logic          wr_en,
  output logic [AW-1:0] wr_row,
  output logic [AW-1:0] wr_col,
  output logic          wr_part,
  input  logic          wr_ready,
  output logic          stall
);

  localparam int LAT = RD_LAT + DP_LAT;
  localparam logic [AW-1:0] LAST_IDX = AW'(DIM - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic          part_q, part_d;

  logic          issue;
  logic          lastIssue;
  logic          rdValid;
  logic          rdPart;
  logic          upstreamBusy;

  // Backpressure only bites when a result is actually being presented.
  assign stall     = wr_en & ~wr_ready;
  assign issue     = (state_q == ST_RUN) & ~stall;
  assign lastIssue = (i_q == LAST_IDX) & (j_q == LAST_IDX) & (part_q == PART_IMAG);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (issue && lastIssue) state_d = ST_DRAIN;
      ST_DRAIN: if (!upstreamBusy && (!wr_en || wr_ready)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Part is the fastest counter, then column, then row; all wrap together after the last issue.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    part_d = part_q;
    if (state_q == ST_IDLE) begin
      i_d    = '0;
      j_d    = '0;
      part_d = PART_REAL;
    end else if (issue) begin
      part_d = ~part_q;
      if (part_q == PART_IMAG) begin
        if (j_q == LAST_IDX) begin
          j_d = '0;
          i_d = (i_q == LAST_IDX) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q    <= '0;
      j_q    <= '0;
      part_q <= PART_REAL;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      part_q <= part_d;
    end
  end

  cmm_tag_pipe #(
    .LAT   (LAT),
    .RD_LAT(RD_LAT),
    .AW    (AW)
  ) u_tag_pipe (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .in_valid_i     (issue),
    .in_row_i       (i_q),
    .in_col_i       (j_q),
    .in_part_i      (part_q),
    .rd_valid_o     (rdValid),
    .rd_part_o      (rdPart),
    .out_valid_o    (wr_en),
    .out_row_o      (wr_row),
    .out_col_o      (wr_col),
    .out_part_o     (wr_part),
    .upstream_busy_o(upstreamBusy)
  );

  // Selector controls follow the tag that is meeting its operand data this cycle.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    rd_en     = (state_q == ST_RUN);
    a_row     = i_q;
    b_col     = j_q;
    sel_state = REAL_SET;
    dp_sub    = 1'b0;
    if (rdValid) begin
      sel_state = (rdPart == PART_IMAG) ? IMAG_SET : REAL_SET;
      dp_sub    = (rdPart == PART_REAL);
    end
  end

endmodule

// File: tb/tb_cmm_sequencer.sv
// Directed self-checking bench for cmm_sequencer: plain, stalled, reset, back-to-back and DIM=1 jobs.
module tb_cmm_sequencer;
  import cmm_sequencer_pkg::*;

  localparam int D = 4;
  localparam int N = 2 * D * D;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, rdEn, selState, dpSub, wrEn, wrPart, wrReady, stall;
  logic [1:0] aRow, bCol, wrRow, wrCol;

  logic       start1, wrReady1;
  logic       busy1, done1, rdEn1, selState1, dpSub1, wrEn1, wrPart1, stall1;
  logic [0:0] aRow1, bCol1, wrRow1, wrCol1;

  int checks = 0;
  int errors = 0;

  cmm_sequencer #(.DIM(D), .RD_LAT(1), .DP_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rdEn), .a_row(aRow), .b_col(bCol), .sel_state(selState), .dp_sub(dpSub),
    .wr_en(wrEn), .wr_row(wrRow), .wr_col(wrCol), .wr_part(wrPart),
    .wr_ready(wrReady), .stall(stall)
  );

  cmm_sequencer #(.DIM(1), .RD_LAT(1), .DP_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rdEn1), .a_row(aRow1), .b_col(bCol1), .sel_state(selState1), .dp_sub(dpSub1),
    .wr_en(wrEn1), .wr_row(wrRow1), .wr_col(wrCol1), .wr_part(wrPart1),
    .wr_ready(wrReady1), .stall(stall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start   = s;
    wrReady = r;
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  // e is the equivalent cycle of an unstalled job started at cycle 0.
  task automatic checkSchedule(input string tn, input int t, input int e);
    int k;
    int p;
    bit expRd, expSel, expWr;
    expRd  = (e >= 1) && (e <= N);
    expSel = (e >= 2) && (e <= N + 1);
    expWr  = (e >= 4) && (e <= N + 3);
    checkOutput($sformatf("%s.busy@%0d", tn, t), busy, 32'((e >= 1) && (e <= N + 4)));
    checkOutput($sformatf("%s.done@%0d", tn, t), done, 32'(e == N + 4));
    checkOutput($sformatf("%s.rd_en@%0d", tn, t), rdEn, 32'(expRd));
    if (expRd) begin
      k = e - 1;
      checkOutput($sformatf("%s.a_row@%0d", tn, t), aRow, 32'(k / (2 * D)));
      checkOutput($sformatf("%s.b_col@%0d", tn, t), bCol, 32'((k / 2) % D));
    end
    p = expSel ? ((e - 2) % 2) : 0;
    checkOutput($sformatf("%s.sel_state@%0d", tn, t), selState,
                32'((expSel && p == 1) ? IMAG_SET : REAL_SET));
    checkOutput($sformatf("%s.dp_sub@%0d", tn, t), dpSub, 32'(expSel && p == 0));
    checkOutput($sformatf("%s.wr_en@%0d", tn, t), wrEn, 32'(expWr));
    if (expWr) begin
      k = e - 4;
      checkOutput($sformatf("%s.wr_row@%0d", tn, t), wrRow, 32'(k / (2 * D)));
      checkOutput($sformatf("%s.wr_col@%0d", tn, t), wrCol, 32'((k / 2) % D));
      checkOutput($sformatf("%s.wr_part@%0d", tn, t), wrPart, 32'(k % 2));
    end
    checkOutput($sformatf("%s.stall@%0d", tn, t), stall, 32'(expWr && !wrReady));
  endtask

  task automatic checkResetValues(input string tn);
    checkOutput({tn, ".busy"}, busy, 0);
    checkOutput({tn, ".done"}, done, 0);
    checkOutput({tn, ".rd_en"}, rdEn, 0);
    checkOutput({tn, ".a_row"}, aRow, 0);
    checkOutput({tn, ".b_col"}, bCol, 0);
    checkOutput({tn, ".sel_state"}, selState, 32'(REAL_SET));
    checkOutput({tn, ".dp_sub"}, dpSub, 0);
    checkOutput({tn, ".wr_en"}, wrEn, 0);
    checkOutput({tn, ".wr_row"}, wrRow, 0);
    checkOutput({tn, ".wr_col"}, wrCol, 0);
    checkOutput({tn, ".wr_part"}, wrPart, 0);
  endtask

  initial begin
    int e;
    rst_n    = 1'b0;
    start    = 1'b0;
    wrReady  = 1'b1;
    start1   = 1'b0;
    wrReady1 = 1'b1;
    repeat (2) nextCycle();
    checkResetValues("por");
    rst_n = 1'b1;

    // Plain job with the sink always ready.
    for (int t = 0; t <= 40; t++) begin
      applyStimulus(t == 0, 1'b1);
      checkSchedule("plain", t, t);
      nextCycle();
    end

    // Sink not ready for cycles 10-14: everything slips by five cycles.
    applyReset();
    for (int t = 0; t <= 45; t++) begin
      applyStimulus(t == 0, !(t >= 10 && t <= 14));
      e = (t < 10) ? t : ((t <= 15) ? 10 : t - 5);
      checkSchedule("stall", t, e);
      nextCycle();
    end

    // Reset asserted during cycle 20, then a fresh job started at cycle 25.
    applyReset();
    for (int t = 0; t <= 65; t++) begin
      rst_n = (t != 20);
      applyStimulus(t == 0 || t == 25, 1'b1);
      if (t == 21) checkResetValues("midreset");
      e = (t <= 20) ? t : ((t < 25) ? 0 : t - 25);
      checkSchedule("reset", t, e);
      nextCycle();
    end
    rst_n = 1'b1;

    // Start held high: one IDLE cycle between jobs, start ignored elsewhere.
    applyReset();
    for (int t = 0; t <= 74; t++) begin
      applyStimulus(1'b1, 1'b1);
      e = (t <= 36) ? t : t - 37;
      checkSchedule("b2b", t, e);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1);
    applyReset();

    // DIM=1: two issues, writes at cycles 4-5, done at cycle 6.
    for (int t = 0; t <= 8; t++) begin
      start1 = (t == 0);
      #1;
      checkOutput($sformatf("dim1.busy@%0d", t), busy1, 32'(t >= 1 && t <= 6));
      checkOutput($sformatf("dim1.done@%0d", t), done1, 32'(t == 6));
      checkOutput($sformatf("dim1.rd_en@%0d", t), rdEn1, 32'(t == 1 || t == 2));
      checkOutput($sformatf("dim1.sel_state@%0d", t), selState1,
                  32'((t == 3) ? IMAG_SET : REAL_SET));
      checkOutput($sformatf("dim1.dp_sub@%0d", t), dpSub1, 32'(t == 2));
      checkOutput($sformatf("dim1.wr_en@%0d", t), wrEn1, 32'(t == 4 || t == 5));
      if (t == 4 || t == 5) begin
        checkOutput($sformatf("dim1.wr_row@%0d", t), wrRow1, 0);
        checkOutput($sformatf("dim1.wr_col@%0d", t), wrCol1, 0);
        checkOutput($sformatf("dim1.wr_part@%0d", t), wrPart1, 32'(t - 4));
      end
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
